// File: rtl/d_reg_arbiter_if.sv
// d_reg_arbiter_if: bundles the requester-side and storage-side signals of the
// shared-register write arbiter.
//   REQ   per-requester write request (bit i = requester i)
//   DIN   packed requester data words, requester i on [i*W +: W]
//   GNT   registered one-hot grant
//   Q     shared register contents
//   QV    one-cycle pulse in the cycle after Q is loaded
//   OWNER index of the requester that last loaded Q
// Modports: master = requester/environment side, slave = arbiter side.
interface d_reg_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int LN = 2
);
  logic [N-1:0]   REQ;
  logic [N*W-1:0] DIN;
  logic [N-1:0]   GNT;
  logic [W-1:0]   Q;
  logic           QV;
  logic [LN-1:0]  OWNER;

  modport master (output REQ, DIN, input GNT, Q, QV, OWNER);
  modport slave  (input REQ, DIN, output GNT, Q, QV, OWNER);
endinterface

// File: rtl/d_reg_arbiter.sv
// d_reg_arbiter: round-robin write sequencer sharing one W-bit register
// between N requesters.
//   C    clock, rising edge
//   RN   asynchronous active-low reset
//   bus  d_reg_arbiter_if.slave (REQ, DIN in; GNT, Q, QV, OWNER out)
//
// state | meaning
// IDLE  | no grant active; pick next requester from PTR upward when REQ != 0
// GRANT | one requester granted; load its word into Q on the next edge
module d_reg_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int LN = 2
) (
  input  logic            C,
  input  logic            RN,
  d_reg_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state;
  logic [LN-1:0] ptr;
  logic [LN-1:0] win;
  logic [N-1:0]  gnt_r;
  logic [W-1:0]  q_r;
  logic          qv_r;
  logic [LN-1:0] owner_r;

  logic [LN-1:0] sel;
  logic          found;
  logic [LN:0]   idx_sum;
  logic [LN-1:0] idx;
  logic [N-1:0]  sel_onehot;
  logic [W-1:0]  din_sel;
  logic [LN-1:0] ptr_next;

  // Scan upward from ptr, wrapping at N, and take the first active request.
  always_comb begin
    sel     = '0;
    found   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx_sum = {1'b0, ptr} + (LN+1)'(i);
      if (idx_sum >= (LN+1)'(N)) idx_sum = idx_sum - (LN+1)'(N);
      idx = idx_sum[LN-1:0];
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_onehot = N'(1) << sel;

  // Data comes from the live DIN of the committed winner, so a requester
  // that withdraws during GRANT still has its word captured at that edge.
  always_comb begin
    din_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (win == LN'(i)) din_sel = bus.DIN[i*W +: W];
    end
  end

  assign ptr_next = (win == LN'(N-1)) ? '0 : win + LN'(1);

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      gnt_r   <= '0;
      q_r     <= '0;
      qv_r    <= 1'b0;
      owner_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          qv_r <= 1'b0;
          if (found) begin
            gnt_r <= sel_onehot;
            win   <= sel;
            state <= GRANT;
          end else begin
            gnt_r <= '0;
          end
        end
        GRANT: begin
          q_r     <= din_sel;
          owner_r <= win;
          qv_r    <= 1'b1;
          ptr     <= ptr_next;
          gnt_r   <= '0;
          state   <= IDLE;
        end
        default: begin
          gnt_r <= '0;
          qv_r  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT   = gnt_r;
  assign bus.Q     = q_r;
  assign bus.QV    = qv_r;
  assign bus.OWNER = owner_r;

endmodule
